keypad_event_ctrl: RTL and testbench
====================================

# keypad_event_ctrl

Debounces the raw 4x4 keypad scan frames produced by the keypad row scanner and converts changes in the stable key map into discrete key events. Events are queued in a small FIFO and handed to the game/menu logic over a valid/ready handshake. The block sits between the keypad scanner and every consumer of key input, so downstream logic never handles raw scan bits.

## Interface
- STABLE_COUNT, 3: consecutive identical frames required before a map is accepted (1..15).
- FIFO_DEPTH, 4: event queue depth, power of two, >= 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- scan_data  in  16  raw frame; bit 4*r+c = row r, column c; 1 = pressed.
- scan_valid  in  1  one-cycle pulse; scan_data holds a complete new frame.
- key_code  out  4  head event key index (bit position in scan_data).
- key_release  out  1  head event is a release (see Configuration).
- key_valid  out  1  FIFO non-empty.
- key_ready  in  1  consumer pops the head when key_valid & key_ready.
- pressed_map  out  16  current debounced key map.
- fifo_count  out  log2(FIFO_DEPTH)+1  queued events.
- overflow  out  1  sticky, an event was dropped.
- clr_overflow  in  1  clears overflow.

## Operation
- Debounce: registers cand[15:0], cnt[3:0]. On scan_valid: if scan_data == cand, cnt <= min(cnt+1, STABLE_COUNT); else cand <= scan_data, cnt <= 1. Cycles without scan_valid hold both.
- Commit: when state == IDLE, cnt == STABLE_COUNT and cand != pressed_map: press_pend <= cand & ~pressed_map, rel_pend <= pressed_map & ~cand, pressed_map <= cand, state <= EMIT. If state == EMIT, commit waits; the newest stable cand is committed on return to IDLE (intermediate stable maps may be skipped).
- FSM states: IDLE, EMIT. In EMIT, one event per cycle: lowest set bit of press_pend; when press_pend == 0, lowest set bit of rel_pend (macro only). Bit cleared in the same cycle. state <= IDLE on the cycle the last pending bit is emitted.
- Push: accepted when fifo_count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the event is dropped, its pending bit is still cleared, and overflow <= 1. EMIT never stalls.
- FIFO: first-word-fall-through; key_code/key_release show the head. Entry = {release, code[3:0]}. Pointers wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves fifo_count unchanged.
- overflow: set wins over clr_overflow in the same cycle.
- Reset values: pressed_map 0, cand 0, cnt 0, pending 0, state IDLE, FIFO empty, key_valid 0, key_code 0, key_release 0, fifo_count 0, overflow 0. Reset mid-EMIT discards all pending and queued events.

## Timing
- Edge E0: scan_valid makes cnt reach STABLE_COUNT. E1: commit, pressed_map updated. E2: first event written; key_valid = 1 after E2. Nth event of the same commit is written at E(N+1).
- Pop takes effect on the edge where key_valid & key_ready; next head visible after that edge.
- key_ready while key_valid = 0 is ignored.

## Configuration
- KEYPAD_RELEASE_EVENT_EN defined: rel_pend is emitted after press_pend, with key_release = 1.
- Not defined: rel_pend is not generated, releases only update pressed_map, and key_release is tied to 0. The entry width stays 5 bits.

## Test plan
- Defaults, three frames of 0x0020 with key_ready = 1: pressed_map = 0x0020 at E1, and a single event code 5, release 0 after E2.
- Bounce 0x0020, 0x0000, 0x0020, 0x0020, 0x0020: no event before the fifth frame, then exactly one event code 5.
- Three frames of 0x8001: events code 0 then code 15 on consecutive cycles, fifo_count peaks at 2 with key_ready = 0.
- key_ready = 0, stable 0x001F: codes 0..3 queued, code 4 dropped, overflow = 1, fifo_count = 4. Then pulse clr_overflow: overflow = 0.
- 0x0020 stable, then 0x0000 stable. With macro: second event code 5, key_release = 1. Without macro: no second event, pressed_map = 0.
- Assert rst during EMIT of 0x00FF: key_valid, fifo_count, pressed_map and overflow read 0 immediately. No events after release until a new stable map arrives.

Source files
------------

// File: rtl/keypad_event_ctrl_if.sv
// Keypad event port bundle: raw scan frames in, debounced key events out.
// The master side is the event controller; the slave side is scanner plus consumer.
interface keypad_event_ctrl_if;
  logic [15:0] scan_data;
  logic        scan_valid;
  logic [3:0]  key_code;
  logic        key_release;
  logic        key_valid;
  logic        key_ready;

  modport master (
    input  scan_data,
    input  scan_valid,
    input  key_ready,
    output key_code,
    output key_release,
    output key_valid
  );

  modport slave (
    output scan_data,
    output scan_valid,
    output key_ready,
    input  key_code,
    input  key_release,
    input  key_valid
  );
endinterface

// File: rtl/keypad_event_ctrl.sv
// Keypad debouncer and key-event queue. Define KEYPAD_RELEASE_EVENT_EN to also queue
// release events (key_release = 1); otherwise releases only update pressed_map.
module keypad_event_ctrl #(
  parameter int unsigned STABLE_COUNT = 3,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  keypad_event_ctrl_if.master          kif,
  output logic [15:0]                  pressed_map,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         clr_overflow
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]      StableCnt = 4'(STABLE_COUNT);
  localparam logic [PtrW:0]   Depth     = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);
  localparam logic [PtrW:0]   CntOne    = (PtrW + 1)'(1);
  localparam logic [0:0]      StIdle    = 1'b0;
  localparam logic [0:0]      StEmit    = 1'b1;

  logic [0:0]      state;
  logic [15:0]     cand, press_pend, press_nxt, clr_mask;
  logic [3:0]      cnt, press_idx, ev_code;
  logic            ev_valid, ev_rel, commit, pend_done;
  logic            head_valid, pop, push, full;
  logic [4:0]      mem [FIFO_DEPTH];
  logic [4:0]      head;
  logic [PtrW-1:0] wr_ptr, rd_ptr;
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic [15:0]     rel_pend, rel_nxt;
  logic [3:0]      rel_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (kif.scan_valid) begin
      if (kif.scan_data == cand) begin
        if (cnt < StableCnt) cnt <= cnt + 4'd1;
      end else begin
        cand <= kif.scan_data;
        cnt  <= 4'd1;
      end
    end
  end

  // Lowest set bit wins.
  always_comb begin
    press_idx = '0;
    for (int i = 15; i >= 0; i--) if (press_pend[i]) press_idx = 4'(i);
`ifdef KEYPAD_RELEASE_EVENT_EN
    rel_idx = '0;
    for (int i = 15; i >= 0; i--) if (rel_pend[i]) rel_idx = 4'(i);
`endif
  end

  always_comb begin
    commit = (state == StIdle) && (cnt == StableCnt) && (cand != pressed_map);
`ifdef KEYPAD_RELEASE_EVENT_EN
    ev_valid  = (press_pend != '0) || (rel_pend != '0);
    ev_rel    = (press_pend == '0);
    ev_code   = ev_rel ? rel_idx : press_idx;
    clr_mask  = 16'(1) << ev_code;
    press_nxt = ev_rel ? press_pend : (press_pend & ~clr_mask);
    rel_nxt   = ev_rel ? (rel_pend & ~clr_mask) : rel_pend;
    pend_done = (press_nxt == '0) && (rel_nxt == '0);
`else
    ev_valid  = (press_pend != '0);
    ev_rel    = 1'b0;
    ev_code   = press_idx;
    clr_mask  = 16'(1) << ev_code;
    press_nxt = press_pend & ~clr_mask;
    pend_done = (press_nxt == '0);
`endif
    head_valid = (fifo_count != '0);
    full       = (fifo_count == Depth);
    pop        = head_valid & kif.key_ready;
    // A pop on the same edge frees the slot the push needs.
    push       = ev_valid & (~full | pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      pressed_map <= '0;
      press_pend  <= '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      rel_pend    <= '0;
`endif
      overflow    <= 1'b0;
    end else begin
      if (ev_valid && !push) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;

      if (state == StIdle) begin
        if (commit) begin
          press_pend  <= cand & ~pressed_map;
`ifdef KEYPAD_RELEASE_EVENT_EN
          rel_pend    <= pressed_map & ~cand;
`endif
          pressed_map <= cand;
          state       <= StEmit;
        end
      end else begin
        press_pend <= press_nxt;
`ifdef KEYPAD_RELEASE_EVENT_EN
        rel_pend   <= rel_nxt;
`endif
        if (pend_done) state <= StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {ev_rel, ev_code};
        wr_ptr      <= wr_ptr + PtrOne;
      end
      if (pop) rd_ptr <= rd_ptr + PtrOne;
      if (push && !pop) fifo_count <= fifo_count + CntOne;
      else if (!push && pop) fifo_count <= fifo_count - CntOne;
    end
  end

  // ev_rel is constant 0 without release events, so the stored release bit reads 0.
  assign head            = mem[rd_ptr];
  assign kif.key_valid   = head_valid;
  assign kif.key_code    = head_valid ? head[3:0] : 4'd0;
  assign kif.key_release = head_valid & head[4];
endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Self-checking bench for keypad_event_ctrl: directed timing sequences, a vector table
// and randomized frames checked against a per-frame reference model.
module tb_keypad_event_ctrl;
  localparam int unsigned S   = 3;
  localparam int unsigned D   = 4;
  localparam int          GAP = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_overflow = 1'b0;
  logic [15:0] pressed_map;
  logic [2:0]  fifo_count;
  logic        overflow;

  keypad_event_ctrl_if kif();

  keypad_event_ctrl #(.STABLE_COUNT(S), .FIFO_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .kif          (kif),
    .pressed_map  (pressed_map),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  dut_q[$];
  logic [4:0]  exp_q[$];
  logic [15:0] m_cand, m_map;
  int          m_cnt;

  typedef struct {
    logic [15:0] frame;
    logic [15:0] exp_map;
    int          exp_n;
    logic [4:0]  exp_first;
  } vec_t;
  vec_t tbl[5];

  // Record every accepted pop; the pop lands on the following rising edge.
  always @(negedge clk)
    if (mon_en && kif.key_valid && kif.key_ready)
      dut_q.push_back({kif.key_release, kif.key_code});

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [15:0] f);
    kif.scan_data  = f;
    kif.scan_valid = 1'b1;
    step(1);
    kif.scan_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    kif.scan_data  = '0;
    kif.scan_valid = 1'b0;
    kif.key_ready  = 1'b0;
    clr_overflow   = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Reference: per-frame debounce rule, events listed from the map difference.
  task automatic model_frame(input logic [15:0] f);
    if (f == m_cand) begin
      if (m_cnt < int'(S)) m_cnt++;
    end else begin
      m_cand = f;
      m_cnt  = 1;
    end
    if (m_cnt == int'(S) && m_cand != m_map) begin
      for (int b = 0; b < 16; b++)
        if (m_cand[b] && !m_map[b]) exp_q.push_back({1'b0, 4'(b)});
`ifdef KEYPAD_RELEASE_EVENT_EN
      for (int b = 0; b < 16; b++)
        if (m_map[b] && !m_cand[b]) exp_q.push_back({1'b1, 4'(b)});
`endif
      m_map = m_cand;
    end
  endtask

  initial begin
    logic [15:0] pal[4];
    int          n;

    tbl[0] = '{16'h0020, 16'h0020, 1, 5'h05};
    tbl[1] = '{16'h8021, 16'h8021, 2, 5'h00};
`ifdef KEYPAD_RELEASE_EVENT_EN
    tbl[2] = '{16'h8001, 16'h8001, 1, 5'h15};
    tbl[3] = '{16'h0000, 16'h0000, 2, 5'h10};
`else
    tbl[2] = '{16'h8001, 16'h8001, 0, 5'h00};
    tbl[3] = '{16'h0000, 16'h0000, 0, 5'h00};
`endif
    tbl[4] = '{16'hF00F, 16'hF00F, 8, 5'h00};

    do_reset();
    check("rst_map", pressed_map, 0);
    check("rst_valid", kif.key_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_code", kif.key_code, 0);
    check("rst_rel", kif.key_release, 0);

    // Latency: E0 -> map at E1 -> first event after E2.
    for (int i = 0; i < 3; i++) pulse(16'h0020);
    check("e0_map", pressed_map, 0);
    step(1);
    check("e1_map", pressed_map, 16'h0020);
    check("e1_valid", kif.key_valid, 0);
    step(1);
    check("e2_valid", kif.key_valid, 1);
    check("e2_code", kif.key_code, 5);
    check("e2_rel", kif.key_release, 0);
    kif.key_ready = 1'b1;
    step(1);
    check("e3_popped", kif.key_valid, 0);

    // Bounce restarts the stability count.
    do_reset();
    pulse(16'h0020); pulse(16'h0000); pulse(16'h0020); pulse(16'h0020);
    step(5);
    check("bounce_map", pressed_map, 0);
    check("bounce_valid", kif.key_valid, 0);
    pulse(16'h0020);
    step(8);
    check("bounce_count", fifo_count, 1);
    check("bounce_code", kif.key_code, 5);

    // Two presses queue on consecutive edges.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(16'h8001);
    step(2);
    check("two_cnt1", fifo_count, 1);
    check("two_head0", kif.key_code, 0);
    step(1);
    check("two_cnt2", fifo_count, 2);
    check("two_head0b", kif.key_code, 0);
    kif.key_ready = 1'b1;
    step(1);
    check("two_head15", kif.key_code, 15);
    check("two_cnt_pop", fifo_count, 1);
    step(1);
    check("two_empty", fifo_count, 0);

    // Overflow on the fifth press, then clear.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(16'h001F);
    step(10);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    check("ovf_clr", overflow, 0);
    kif.key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d", i), kif.key_code, i);
      step(1);
    end
    check("ovf_drained", fifo_count, 0);

    // Reset in the middle of emitting eight presses.
    do_reset();
    for (int i = 0; i < 3; i++) pulse(16'h00FF);
    step(3);
    check("mid_count", fifo_count, 2);
    rst = 1'b1;
    #1;
    check("arst_valid", kif.key_valid, 0);
    check("arst_count", fifo_count, 0);
    check("arst_map", pressed_map, 0);
    check("arst_ovf", overflow, 0);
    step(2);
    rst = 1'b0;
    step(30);
    check("post_rst_count", fifo_count, 0);
    check("post_rst_map", pressed_map, 0);

    // Vector table, applied from reset in order.
    do_reset();
    kif.key_ready = 1'b1;
    mon_en = 1'b1;
    for (int r = 0; r < 5; r++) begin
      dut_q.delete();
      for (int i = 0; i < 3; i++) pulse(tbl[r].frame);
      step(GAP);
      check($sformatf("tbl%0d_map", r), pressed_map, tbl[r].exp_map);
      check($sformatf("tbl%0d_nev", r), dut_q.size(), tbl[r].exp_n);
      if (tbl[r].exp_n > 0 && dut_q.size() > 0)
        check($sformatf("tbl%0d_first", r), dut_q[0], tbl[r].exp_first);
    end

    // Randomized frames against the reference model.
    do_reset();
    kif.key_ready = 1'b1;
    dut_q.delete();
    exp_q.delete();
    m_cand = '0;
    m_map  = '0;
    m_cnt  = 0;
    pal[0] = '0;
    for (int i = 1; i < 4; i++) pal[i] = 16'($urandom());
    for (int f = 0; f < 60; f++) begin
      logic [15:0] fr;
      fr = pal[$urandom_range(0, 3)];
      n  = $urandom_range(1, 4);
      for (int r = 0; r < n; r++) begin
        pulse(fr);
        model_frame(fr);
        step(GAP);
      end
      check($sformatf("rnd%0d_map", f), pressed_map, m_map);
    end
    check("rnd_nev", dut_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++)
      check($sformatf("rnd_ev%0d", i), dut_q[i], exp_q[i]);
    check("rnd_ovf", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
